// File: rtl/pc_pkg.sv
// Shared types and constants for the instruction-fetch program counter.
// The compressed-mode mask is used only when PC_CALIGN_EN is defined.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HELD = 2'd2
  } pc_state_t;

  // One decision per cycle, already resolved in priority order
  typedef enum logic [2:0] {
    ACT_BOOT     = 3'd0,
    ACT_TRAP     = 3'd1,
    ACT_MISALIGN = 3'd2,
    ACT_REDIRECT = 3'd3,
    ACT_CAPTURE  = 3'd4,
    ACT_PENDING  = 3'd5,
    ACT_HOLD     = 3'd6,
    ACT_INC      = 3'd7
  } pc_action_t;

  localparam logic [31:0] DEF_RESET_VECTOR      = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR       = 32'h0000_0100;
  localparam logic [1:0]  ALIGN_MASK_NORMAL     = 2'b11;
  localparam logic [1:0]  ALIGN_MASK_COMPRESSED = 2'b01;

endpackage

// File: rtl/pc_if.sv
// Fetch-stage PC bus: execute/hazard-unit inputs and PC outputs toward instruction memory.
// With PC_CALIGN_EN defined the bus also carries is_compressed.
interface pc_if #(
  parameter int unsigned XLEN = 32
);
`ifdef PC_CALIGN_EN
  logic            is_compressed;
`endif
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            redirect_taken;
  logic            misalign;
  logic [XLEN-1:0] bad_addr;

  modport master (
`ifdef PC_CALIGN_EN
    output is_compressed,
`endif
    output stall, redirect_valid, redirect_target, trap_valid,
    input  pc, pc_valid, redirect_taken, misalign, bad_addr
  );

  modport slave (
`ifdef PC_CALIGN_EN
    input  is_compressed,
`endif
    input  stall, redirect_valid, redirect_target, trap_valid,
    output pc, pc_valid, redirect_taken, misalign, bad_addr
  );
endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry buffer for a redirect that arrived while fetch was stalled.
// Clear (superseded) and consume (applied) both drop the entry; clearing wins over capture.
module pc_redirect_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            clear,
  input  logic            consume,
  input  logic [XLEN-1:0] target_in,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  logic            valid_r;
  logic [XLEN-1:0] target_r;

  // Pending entry register; a later capture overwrites an earlier one
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      target_r <= '0;
    end else if (clear || consume) begin
      valid_r  <= 1'b0;
      target_r <= target_r;
    end else if (capture) begin
      valid_r  <= 1'b1;
      target_r <= target_in;
    end else begin
      valid_r  <= valid_r;
      target_r <= target_r;
    end
  end

  assign pend_valid  = valid_r;
  assign pend_target = target_r;

endmodule

// File: rtl/pc_unit.sv
// Program counter for instruction fetch: sequential advance, stall, buffered redirects, trap vectoring.
// Define PC_CALIGN_EN for compressed-instruction support (2-byte step, halfword alignment).
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter int unsigned     INC          = 4
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);

  pc_state_t       state_r;
  logic [XLEN-1:0] pc_r;
  logic            pc_valid_r;
  logic            redirect_taken_r;
  logic            misalign_r;
  logic [XLEN-1:0] bad_addr_r;

  pc_action_t      act_s;
  logic            misaligned_s;
  logic [XLEN-1:0] inc_s;
  logic            pend_valid_s;
  logic [XLEN-1:0] pend_target_s;
  logic            capture_s;
  logic            clear_s;
  logic            consume_s;

`ifdef PC_CALIGN_EN
  assign misaligned_s = |(bus.redirect_target[1:0] & ALIGN_MASK_COMPRESSED);

  // Compressed instructions advance by a halfword
  always_comb begin
    if (bus.is_compressed) begin
      inc_s = XLEN'(32'd2);
    end else begin
      inc_s = XLEN'(INC);
    end
  end
`else
  assign misaligned_s = |(bus.redirect_target[1:0] & ALIGN_MASK_NORMAL);
  assign inc_s        = XLEN'(INC);
`endif

  // Resolve this cycle's action; order of the chain is the priority order
  always_comb begin
    act_s = ACT_HOLD;
    if (state_r == BOOT) begin
      act_s = ACT_BOOT;
    end else if (bus.trap_valid) begin
      act_s = ACT_TRAP;
    end else if (bus.redirect_valid && misaligned_s) begin
      act_s = ACT_MISALIGN;
    end else if (bus.redirect_valid && !bus.stall) begin
      act_s = ACT_REDIRECT;
    end else if (bus.redirect_valid) begin
      act_s = ACT_CAPTURE;
    end else if (pend_valid_s && !bus.stall) begin
      act_s = ACT_PENDING;
    end else if (bus.stall) begin
      act_s = ACT_HOLD;
    end else begin
      act_s = ACT_INC;
    end
  end

  assign capture_s = (act_s == ACT_CAPTURE);
  assign consume_s = (act_s == ACT_PENDING);
  assign clear_s   = (act_s == ACT_TRAP) || (act_s == ACT_MISALIGN) || (act_s == ACT_REDIRECT);

  pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture_s),
    .clear       (clear_s),
    .consume     (consume_s),
    .target_in   (bus.redirect_target),
    .pend_valid  (pend_valid_s),
    .pend_target (pend_target_s)
  );

  // PC state machine with registered outputs; flush pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= BOOT;
      pc_r             <= RESET_VECTOR;
      pc_valid_r       <= 1'b0;
      redirect_taken_r <= 1'b0;
      misalign_r       <= 1'b0;
      bad_addr_r       <= '0;
    end else begin
      redirect_taken_r <= 1'b0;
      misalign_r       <= 1'b0;
      case (act_s)
        ACT_BOOT: begin
          state_r    <= RUN;
          pc_valid_r <= 1'b1;
        end
        ACT_TRAP: begin
          state_r          <= RUN;
          pc_r             <= TRAP_VECTOR;
          redirect_taken_r <= 1'b1;
        end
        ACT_MISALIGN: begin
          state_r          <= RUN;
          pc_r             <= TRAP_VECTOR;
          redirect_taken_r <= 1'b1;
          misalign_r       <= 1'b1;
          bad_addr_r       <= bus.redirect_target;
        end
        ACT_REDIRECT: begin
          state_r          <= RUN;
          pc_r             <= bus.redirect_target;
          redirect_taken_r <= 1'b1;
        end
        ACT_CAPTURE: begin
          state_r <= HELD;
        end
        ACT_PENDING: begin
          state_r          <= RUN;
          pc_r             <= pend_target_s;
          redirect_taken_r <= 1'b1;
        end
        ACT_HOLD: begin
          state_r <= state_r;
        end
        ACT_INC: begin
          pc_r <= pc_r + inc_s;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  assign bus.pc             = pc_r;
  assign bus.pc_valid       = pc_valid_r;
  assign bus.redirect_taken = redirect_taken_r;
  assign bus.misalign       = misalign_r;
  assign bus.bad_addr       = bad_addr_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table walking the fetch scenarios, plus hand-written
// sequences for latest-wins buffering, misaligned-while-stalled and inputs ignored in BOOT.
module tb_pc_unit;

  localparam int unsigned XLEN = 32;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_taken;
    logic        exp_mis;
    logic [31:0] exp_bad;
  } vec_t;

  logic clk;
  logic rst;
  int   total_cnt;
  int   pass_cnt;
  vec_t tbl[$];

  pc_if #(.XLEN(XLEN)) bus ();

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_1000),
    .TRAP_VECTOR  (32'h0000_0100),
    .INC          (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string name, input logic r, input logic st, input logic rv,
                              input logic [31:0] tgt, input logic tr, input logic [31:0] epc,
                              input logic ev, input logic et, input logic em, input logic [31:0] eb);
    vec_t v;
    v.name = name; v.rst = r; v.stall = st; v.rv = rv; v.tgt = tgt; v.trap = tr;
    v.exp_pc = epc; v.exp_valid = ev; v.exp_taken = et; v.exp_mis = em; v.exp_bad = eb;
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge happen, then compare all outputs
  task automatic apply(input vec_t v);
    rst                 = v.rst;
    bus.stall           = v.stall;
    bus.redirect_valid  = v.rv;
    bus.redirect_target = v.tgt;
    bus.trap_valid      = v.trap;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.pc === v.exp_pc && bus.pc_valid === v.exp_valid && bus.redirect_taken === v.exp_taken
        && bus.misalign === v.exp_mis && bus.bad_addr === v.exp_bad) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got pc=%h valid=%b taken=%b mis=%b bad=%h, want pc=%h valid=%b taken=%b mis=%b bad=%h",
               v.name, bus.pc, bus.pc_valid, bus.redirect_taken, bus.misalign, bus.bad_addr,
               v.exp_pc, v.exp_valid, v.exp_taken, v.exp_mis, v.exp_bad);
    end
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    bus.trap_valid = 1'b0;
`ifdef PC_CALIGN_EN
    bus.is_compressed = 1'b0;
`endif

    //              name            rst   stall rv    tgt           trap  pc            v     tk    mis   bad
    tbl.push_back(mk("reset",       1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("boot_exit",   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("inc_1004",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("inc_1008",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1008, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("stall_1",     1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_1008, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("stall_2",     1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_1008, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("unstall",     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_100C, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("capture",     1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_100C, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("held_1",      1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_100C, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("held_2",      1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_100C, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("pend_apply",  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_2000, 1'b1, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk("after_pend",  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_2004, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("misaligned",  1'b0, 1'b0, 1'b1, 32'h0000_2002, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 32'h0000_2002));
    tbl.push_back(mk("redir_3000",  1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("inc_3004",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("capture_4k",  1'b0, 1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'h0000_3004, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("trap_stall",  1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("trap_held",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("trap_inc",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("redir_top",   1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("inc_fffc",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("wrap_0",      1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("wrap_4",      1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("capture_5k",  1'b0, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0000_2002));
    tbl.push_back(mk("rst_pending", 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("rst_boot",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0));
    tbl.push_back(mk("rst_no_pend", 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // Latest pending redirect wins, then a misaligned target rejected while stalled
    apply(mk("lw_cap_a",    1'b0, 1'b1, 1'b1, 32'h0000_6000, 1'b0, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 32'h0));
    apply(mk("lw_cap_b",    1'b0, 1'b1, 1'b1, 32'h0000_7000, 1'b0, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 32'h0));
    apply(mk("lw_apply",    1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_7000, 1'b1, 1'b1, 1'b0, 32'h0));
    apply(mk("mis_stalled", 1'b0, 1'b1, 1'b1, 32'h0000_7001, 1'b0, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 32'h0000_7001));
    apply(mk("mis_no_pend", 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 32'h0000_7001));
    apply(mk("mis_resume",  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0104, 1'b1, 1'b0, 1'b0, 32'h0000_7001));

    // Trap and redirect during the BOOT cycle are ignored
    apply(mk("rst_again",   1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 32'h0));
    apply(mk("boot_ignore", 1'b0, 1'b0, 1'b1, 32'h0000_8000, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 32'h0));
    apply(mk("boot_after",  1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_1004, 1'b1, 1'b0, 1'b0, 32'h0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
